// File: rtl/floppy_pkg.sv
// Shared definitions for the Disk II SD-port sharing logic.
//   state_t           arbiter state encoding (IDLE, BUSY, RELEASE)
//   SECTORS_PER_TRACK sectors moved by one track loader burst
//   LBA_W             width of a block address on the SD port
//   MAX_REQ           largest supported number of requesting drives
package floppy_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RELEASE = 2'd2
    } state_t;

    localparam int SECTORS_PER_TRACK = 13;
    localparam int LBA_W             = 32;
    localparam int MAX_REQ           = 4;

endpackage

// File: rtl/floppy_sd_arbiter_rr_pick.sv
// Combinational round-robin finder.
//   pend  in  N  pending request vector
//   ptr   in  2  first index to consider (search wraps modulo N)
//   hit   out 1  at least one request pending
//   idx   out 2  index of the first pending request at or after ptr
module rr_pick #(
    parameter int N = 2
) (
    input  logic [N-1:0] pend,
    input  logic [1:0]   ptr,
    output logic         hit,
    output logic [1:0]   idx
);

    // Two passes avoid modulo arithmetic: first the indices at or above
    // the pointer, then the wrapped-around indices below it.
    always_comb begin
        hit = 1'b0;
        idx = 2'd0;
        for (int i = 0; i < N; i++) begin
            if (!hit && pend[i] && (2'(i) >= ptr)) begin
                hit = 1'b1;
                idx = 2'(i);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!hit && pend[i] && (2'(i) < ptr)) begin
                hit = 1'b1;
                idx = 2'(i);
            end
        end
    end

endmodule

// File: rtl/floppy_sd_arbiter.sv
// Shares the single SD block-device port between N_REQ Disk II track
// loaders. One loader owns the port for a whole multi-sector burst;
// selection is round-robin and a watchdog frees the port if the host
// stops acknowledging.
//   clk, reset          clock, synchronous active-high reset
//   req_rd/req_wr       per-drive read/write requests
//   req_lba             per-drive LBA, slice i = [32*i+31:32*i]
//   req_buff_din        per-drive buffer read data
//   req_ack/req_buff_wr host ack / buffer write routed to granted drive
//   sd_lba/sd_rd/sd_wr  request to host
//   sd_ack/sd_buff_wr   host acknowledge / buffer write strobe
//   sd_buff_din         buffer data to host from granted drive
//   busy, grant_idx     grant status
//   sectors_done        ack falling edges in current burst (saturating)
//   timeout_pulse       one-cycle pulse on watchdog release
//   proto_err           one-cycle pulse per cycle with rd and wr both high
module floppy_sd_arbiter
    import floppy_pkg::*;
#(
    parameter int          N_REQ   = 2,
    parameter logic [23:0] TIMEOUT = 24'd12_000_000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req_rd,
    input  logic [N_REQ-1:0]       req_wr,
    input  logic [LBA_W*N_REQ-1:0] req_lba,
    input  logic [8*N_REQ-1:0]     req_buff_din,
    output logic [N_REQ-1:0]       req_ack,
    output logic [N_REQ-1:0]       req_buff_wr,
    output logic [LBA_W-1:0]       sd_lba,
    output logic                   sd_rd,
    output logic                   sd_wr,
    input  logic                   sd_ack,
    input  logic                   sd_buff_wr,
    output logic [7:0]             sd_buff_din,
    output logic                   busy,
    output logic [1:0]             grant_idx,
    output logic [3:0]             sectors_done,
    output logic                   timeout_pulse,
    output logic                   proto_err
);

    localparam logic [1:0] LAST = 2'(N_REQ - 1);

    state_t          state, state_next;
    logic [1:0]      rr_ptr;
    logic            ack_q;
    logic [23:0]     watchdog;

    logic            pick_hit;
    logic [1:0]      pick_idx;
    logic            g_rd, g_wr;
    logic [LBA_W-1:0] g_lba;
    logic [7:0]      g_din;
    logic            rise, fall;
    logic            do_grant, do_timeout;

    assign rise = sd_ack & ~ack_q;
    assign fall = ~sd_ack & ack_q;

    rr_pick #(.N(N_REQ)) u_pick (
        .pend (req_rd | req_wr),
        .ptr  (rr_ptr),
        .hit  (pick_hit),
        .idx  (pick_idx)
    );

    // Mux the granted drive's signals and route host strobes back to it.
    always_comb begin
        g_rd  = 1'b0;
        g_wr  = 1'b0;
        g_lba = '0;
        g_din = 8'd0;
        for (int i = 0; i < N_REQ; i++) begin
            req_ack[i]     = sd_ack & busy & (grant_idx == 2'(i));
            req_buff_wr[i] = sd_buff_wr & busy & (grant_idx == 2'(i));
            if (grant_idx == 2'(i)) begin
                g_rd  = req_rd[i];
                g_wr  = req_wr[i];
                g_lba = req_lba[LBA_W*i +: LBA_W];
                g_din = req_buff_din[8*i +: 8];
            end
        end
        sd_buff_din = busy ? g_din : 8'd0;
    end

    always_comb begin
        state_next = state;
        do_grant   = 1'b0;
        do_timeout = 1'b0;
        case (state)
            IDLE: begin
                if (pick_hit) begin
                    state_next = BUSY;
                    do_grant   = 1'b1;
                end
            end
            BUSY: begin
                // Waiting for ack_q low as well lets a loader chain a new
                // request while the last ack is still high without losing
                // the port.
                if (!(g_rd | g_wr) && !sd_ack && !ack_q) begin
                    state_next = RELEASE;
                end else if (watchdog == TIMEOUT - 24'd1) begin
                    state_next = RELEASE;
                    do_timeout = 1'b1;
                end
            end
            RELEASE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            rr_ptr        <= 2'd0;
            ack_q         <= 1'b0;
            watchdog      <= 24'd0;
            grant_idx     <= 2'd0;
            busy          <= 1'b0;
            sectors_done  <= 4'd0;
            sd_lba        <= '0;
            sd_rd         <= 1'b0;
            sd_wr         <= 1'b0;
            timeout_pulse <= 1'b0;
            proto_err     <= 1'b0;
        end else begin
            state         <= state_next;
            ack_q         <= sd_ack;
            timeout_pulse <= do_timeout;
            proto_err     <= 1'b0;
            case (state)
                IDLE: begin
                    if (do_grant) begin
                        grant_idx    <= pick_idx;
                        busy         <= 1'b1;
                        sectors_done <= 4'd0;
                        watchdog     <= 24'd0;
                    end
                end
                BUSY: begin
                    // Registered one cycle late; the host only samples the
                    // LBA at rd/wr assertion or after an ack fall.
                    sd_lba    <= g_lba;
                    sd_wr     <= g_wr;
                    sd_rd     <= g_rd & ~g_wr;
                    proto_err <= g_rd & g_wr;
                    if (fall && sectors_done != 4'd15) begin
                        sectors_done <= sectors_done + 4'd1;
                    end
                    if (rise || fall) begin
                        watchdog <= 24'd0;
                    end else begin
                        watchdog <= watchdog + 24'd1;
                    end
                    if (do_timeout) begin
                        sd_rd <= 1'b0;
                        sd_wr <= 1'b0;
                    end
                end
                RELEASE: begin
                    sd_rd  <= 1'b0;
                    sd_wr  <= 1'b0;
                    busy   <= 1'b0;
                    rr_ptr <= (grant_idx == LAST) ? 2'd0 : grant_idx + 2'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_floppy_sd_arbiter.sv
module tb_floppy_sd_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_rd, req_wr;
    logic [63:0] req_lba;
    logic [15:0] req_buff_din;
    logic [1:0]  req_ack, req_buff_wr;
    logic [31:0] sd_lba;
    logic        sd_rd, sd_wr, sd_ack, sd_buff_wr;
    logic [7:0]  sd_buff_din;
    logic        busy;
    logic [1:0]  grant_idx;
    logic [3:0]  sectors_done;
    logic        timeout_pulse, proto_err;

    int tests = 0;
    int fails = 0;
    int ab, lb, db, bb;

    always #5 clk = ~clk;

    floppy_sd_arbiter #(.N_REQ(2), .TIMEOUT(24'd100)) dut (
        .clk(clk), .reset(reset),
        .req_rd(req_rd), .req_wr(req_wr), .req_lba(req_lba),
        .req_buff_din(req_buff_din),
        .req_ack(req_ack), .req_buff_wr(req_buff_wr),
        .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr),
        .sd_ack(sd_ack), .sd_buff_wr(sd_buff_wr), .sd_buff_din(sd_buff_din),
        .busy(busy), .grant_idx(grant_idx), .sectors_done(sectors_done),
        .timeout_pulse(timeout_pulse), .proto_err(proto_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req_rd = 2'b00; req_wr = 2'b00; req_lba = '0;
        req_buff_din = 16'h0000; sd_ack = 1'b0; sd_buff_wr = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Host + loader model for one burst. last_mode: 0 drop request at the
    // final ack rise, 1 switch write to read at the next LBA, 2 keep.
    task automatic burst(input int drv, input logic [31:0] lba0, input bit is_wr,
                         input int nsec, input int last_mode,
                         output int ack_bad, output int lba_bad,
                         output int din_bad, output int busy_bad);
        logic [1:0]  exp;
        logic [31:0] lba;
        logic [7:0]  b;
        exp = 2'(1 << drv);
        lba = lba0;
        ack_bad = 0; lba_bad = 0; din_bad = 0; busy_bad = 0;
        for (int s = 0; s < nsec; s++) begin
            tick(); if (busy !== 1'b1) busy_bad++;
            tick(); if (busy !== 1'b1) busy_bad++;
            if (sd_lba !== lba) lba_bad++;
            if (is_wr) begin
                b = 8'hA0 + 8'(s);
                req_buff_din[8*drv +: 8] = b;
                #1;
                if (sd_buff_din !== b) din_bad++;
            end
            sd_ack = 1'b1;
            sd_buff_wr = !is_wr;
            #1;
            if (req_ack !== exp) ack_bad++;
            if (!is_wr && req_buff_wr !== exp) ack_bad++;
            tick(); if (busy !== 1'b1) busy_bad++;
            if (s == nsec - 1) begin
                if (last_mode == 0) begin
                    req_rd[drv] = 1'b0; req_wr[drv] = 1'b0;
                end else if (last_mode == 1) begin
                    req_wr[drv] = 1'b0; req_rd[drv] = 1'b1;
                    req_lba[32*drv +: 32] = lba + 32'd1;
                end
            end else begin
                lba = lba + 32'd1;
                req_lba[32*drv +: 32] = lba;
            end
            sd_buff_wr = 1'b0;
            if (req_ack !== exp) ack_bad++;
            tick(); if (busy !== 1'b1) busy_bad++;
            sd_ack = 1'b0;
        end
    endtask

    task automatic test_reset();
        do_reset();
        req_buff_din = 16'h3C5A;
        #1;
        tests++;
        if (busy !== 1'b0 || sd_rd !== 1'b0 || sd_wr !== 1'b0 || grant_idx !== 2'd0 ||
            sectors_done !== 4'd0 || timeout_pulse !== 1'b0 || proto_err !== 1'b0 || sd_lba !== 32'd0) begin
            fails++;
            $display("FAIL reset_state: busy=%b rd=%b wr=%b g=%0d sd=%0d to=%b pe=%b lba=%0h, required all zero",
                     busy, sd_rd, sd_wr, grant_idx, sectors_done, timeout_pulse, proto_err, sd_lba);
        end
        tests++;
        if (sd_buff_din !== 8'h00) begin
            fails++;
            $display("FAIL idle_din: got %0h required 00", sd_buff_din);
        end
        sd_ack = 1'b1; sd_buff_wr = 1'b1; #1;
        tests++;
        if (req_ack !== 2'b00 || req_buff_wr !== 2'b00) begin
            fails++;
            $display("FAIL idle_ack_route: ack=%b bwr=%b required 00 00", req_ack, req_buff_wr);
        end
        sd_ack = 1'b0; sd_buff_wr = 1'b0;
    endtask

    task automatic test_single_read();
        do_reset();
        req_rd[0] = 1'b1; req_lba[31:0] = 32'h1A;
        tick();
        tests++;
        if (busy !== 1'b1 || sd_rd !== 1'b0 || grant_idx !== 2'd0) begin
            fails++;
            $display("FAIL sr_grant: busy=%b rd=%b g=%0d required 1 0 0", busy, sd_rd, grant_idx);
        end
        tick();
        tests++;
        if (sd_rd !== 1'b1 || sd_lba !== 32'h1A) begin
            fails++;
            $display("FAIL sr_rd_latency: rd=%b lba=%0h required 1 1a", sd_rd, sd_lba);
        end
        burst(0, 32'h1A, 1'b0, 13, 0, ab, lb, db, bb);
        tests++;
        if (ab !== 0 || lb !== 0 || bb !== 0) begin
            fails++;
            $display("FAIL sr_burst: ack_bad=%0d lba_bad=%0d busy_bad=%0d required 0", ab, lb, bb);
        end
        tick();
        tests++;
        if (sectors_done !== 4'd13 || busy !== 1'b1) begin
            fails++;
            $display("FAIL sr_count: sectors=%0d busy=%b required 13 1", sectors_done, busy);
        end
        tick();
        tick();
        tests++;
        if (busy !== 1'b0 || sd_rd !== 1'b0 || sectors_done !== 4'd13) begin
            fails++;
            $display("FAIL sr_release: busy=%b rd=%b sectors=%0d required 0 0 13", busy, sd_rd, sectors_done);
        end
    endtask

    task automatic test_contention();
        do_reset();
        req_rd = 2'b11; req_lba = {32'h20, 32'h10};
        tick();
        tests++;
        if (grant_idx !== 2'd0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL ct_first: g=%0d busy=%b required 0 1", grant_idx, busy);
        end
        burst(0, 32'h10, 1'b0, 1, 0, ab, lb, db, bb);
        tests++;
        if (ab !== 0 || lb !== 0 || bb !== 0) begin
            fails++;
            $display("FAIL ct_burst0: ack_bad=%0d lba_bad=%0d busy_bad=%0d required 0", ab, lb, bb);
        end
        tick(); tick(); tick();
        tests++;
        if (busy !== 1'b0 || sd_rd !== 1'b0) begin
            fails++;
            $display("FAIL ct_gap: busy=%b rd=%b required 0 0", busy, sd_rd);
        end
        tick();
        tests++;
        if (grant_idx !== 2'd1 || busy !== 1'b1) begin
            fails++;
            $display("FAIL ct_second: g=%0d busy=%b required 1 1", grant_idx, busy);
        end
        burst(1, 32'h20, 1'b0, 1, 0, ab, lb, db, bb);
        tests++;
        if (ab !== 0 || lb !== 0 || bb !== 0) begin
            fails++;
            $display("FAIL ct_burst1: ack_bad=%0d lba_bad=%0d busy_bad=%0d required 0", ab, lb, bb);
        end
        tick(); tick(); tick();
        req_rd[0] = 1'b1; req_lba[31:0] = 32'h30;
        tick();
        burst(0, 32'h30, 1'b0, 1, 0, ab, lb, db, bb);
        tick(); tick(); tick();
        req_rd = 2'b11;
        tick();
        tests++;
        if (grant_idx !== 2'd1 || busy !== 1'b1) begin
            fails++;
            $display("FAIL ct_rr: g=%0d busy=%b required 1 1", grant_idx, busy);
        end
    endtask

    task automatic test_write_then_read();
        do_reset();
        req_wr[0] = 1'b1; req_lba[31:0] = 32'h100; req_buff_din[15:8] = 8'h55;
        tick();
        tick();
        tests++;
        if (sd_wr !== 1'b1 || sd_rd !== 1'b0) begin
            fails++;
            $display("FAIL wr_start: wr=%b rd=%b required 1 0", sd_wr, sd_rd);
        end
        burst(0, 32'h100, 1'b1, 13, 1, ab, lb, db, bb);
        tests++;
        if (ab !== 0 || lb !== 0 || db !== 0 || bb !== 0) begin
            fails++;
            $display("FAIL wr_burst: ack_bad=%0d lba_bad=%0d din_bad=%0d busy_bad=%0d required 0", ab, lb, db, bb);
        end
        burst(0, 32'h10D, 1'b0, 13, 0, ab, lb, db, bb);
        tests++;
        if (ab !== 0 || lb !== 0 || bb !== 0) begin
            fails++;
            $display("FAIL wr_chain_rd: ack_bad=%0d lba_bad=%0d busy_bad=%0d required 0", ab, lb, bb);
        end
        tick();
        tests++;
        if (sectors_done !== 4'd15) begin
            fails++;
            $display("FAIL wr_saturate: sectors=%0d required 15", sectors_done);
        end
        tick(); tick();
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL wr_release: busy=%b required 0", busy);
        end
    endtask

    task automatic test_timeout();
        int bad;
        do_reset();
        req_rd[1] = 1'b1;
        tick();
        req_rd[0] = 1'b1;
        bad = 0;
        for (int k = 1; k < 100; k++) begin
            tick();
            if (timeout_pulse !== 1'b0 || busy !== 1'b1) bad++;
        end
        tests++;
        if (bad !== 0 || sd_rd !== 1'b1 || grant_idx !== 2'd1) begin
            fails++;
            $display("FAIL to_wait: early=%0d rd=%b g=%0d required 0 1 1", bad, sd_rd, grant_idx);
        end
        tick();
        tests++;
        if (timeout_pulse !== 1'b1 || sd_rd !== 1'b0) begin
            fails++;
            $display("FAIL to_pulse: pulse=%b rd=%b required 1 0", timeout_pulse, sd_rd);
        end
        tick();
        tests++;
        if (busy !== 1'b0 || timeout_pulse !== 1'b0) begin
            fails++;
            $display("FAIL to_release: busy=%b pulse=%b required 0 0", busy, timeout_pulse);
        end
        tick();
        tests++;
        if (busy !== 1'b1 || grant_idx !== 2'd0) begin
            fails++;
            $display("FAIL to_next: busy=%b g=%0d required 1 0", busy, grant_idx);
        end
    endtask

    task automatic test_proto_err();
        do_reset();
        req_wr[0] = 1'b1;
        tick();
        tick();
        req_rd[0] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            tests++;
            if (proto_err !== 1'b1 || sd_wr !== 1'b1 || sd_rd !== 1'b0) begin
                fails++;
                $display("FAIL pe_cycle%0d: pe=%b wr=%b rd=%b required 1 1 0", k, proto_err, sd_wr, sd_rd);
            end
        end
        req_rd[0] = 1'b0;
        tick();
        tests++;
        if (proto_err !== 1'b0 || sd_wr !== 1'b1) begin
            fails++;
            $display("FAIL pe_clear: pe=%b wr=%b required 0 1", proto_err, sd_wr);
        end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        req_rd[1] = 1'b1; req_lba[63:32] = 32'h40;
        tick();
        burst(1, 32'h40, 1'b0, 5, 2, ab, lb, db, bb);
        tick();
        tests++;
        if (sectors_done !== 4'd5 || sd_rd !== 1'b1 || grant_idx !== 2'd1) begin
            fails++;
            $display("FAIL rm_pre: sectors=%0d rd=%b g=%0d required 5 1 1", sectors_done, sd_rd, grant_idx);
        end
        reset = 1'b1;
        tick();
        tests++;
        if (sd_rd !== 1'b0 || busy !== 1'b0 || grant_idx !== 2'd0) begin
            fails++;
            $display("FAIL rm_after: rd=%b busy=%b g=%0d required 0 0 0", sd_rd, busy, grant_idx);
        end
        reset = 1'b0;
        req_rd = 2'b00;
        sd_ack = 1'b1; sd_buff_wr = 1'b1; #1;
        tests++;
        if (req_ack !== 2'b00 || req_buff_wr !== 2'b00) begin
            fails++;
            $display("FAIL rm_stray_ack: ack=%b bwr=%b required 00 00", req_ack, req_buff_wr);
        end
        tick();
        sd_ack = 1'b0; sd_buff_wr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_contention();
        test_write_then_read();
        test_timeout();
        test_proto_err();
        test_reset_mid_burst();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
